muldiv_ctrl: RTL and testbench

//   Sequencer for the multicycle mult/div unit. Accepts one mult/div request at a time from the

---
 rtl/muldiv_ctrl.sv | 147 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Sequences one mult/div operation at a time: holds unit_ctrl for N cycles, then commits or aborts.
// Latency: accept in cycle 0, RUN 1..N, hilo_we N+1, done N+2, ready again N+3 (div0 abort: exc next cycle).
// Backpressure: req_ready is high only in IDLE; the requester holds req_valid/req_op until accepted.
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 33,
    parameter int DIV_CYCLES  = 33,
    parameter int CNT_W       = 6
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req_valid,
    input  logic [1:0] i_req_op,
    output logic       o_req_ready,
    output logic [1:0] o_unit_ctrl,
    input  logic       i_unit_div0,
    output logic       o_hilo_we,
    output logic       o_done,
    output logic       o_div0_exc,
    output logic       o_illegal_op,
    output logic       o_busy,
    input  logic       i_hilo_rd_req,
    output logic       o_stall
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DONE    = 3'd3,
        ST_EXC     = 3'd4
    } state_t;

    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_MULT = 2'd2;

    // Counter preload: RUN lasts exactly N cycles, ending on the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic             r_illegal;

    logic             w_op_legal;
    logic             w_div0_abort;

    assign w_op_legal   = (i_req_op == OP_DIV) || (i_req_op == OP_MULT);
    // The zero-divisor flag only matters for a divide; a mult ignores it entirely.
    assign w_div0_abort = (r_op == OP_DIV) && i_unit_div0;

    // Sequencer FSM: state, cycle counter, latched op and the dropped-request pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_op      <= OP_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        if (w_op_legal) begin
                            r_op    <= i_req_op;
                            r_cnt   <= (i_req_op == OP_DIV) ? DIV_LOAD : MULT_LOAD;
                            r_state <= ST_RUN;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Divide-by-zero wins over normal completion, even on the last RUN cycle.
                    if (w_div0_abort) begin
                        r_state <= ST_EXC;
                    end else if (r_cnt == CNT_ZERO) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_op    <= OP_IDLE;
                    r_state <= ST_IDLE;
                end
                ST_EXC: begin
                    r_op    <= OP_IDLE;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_op    <= OP_IDLE;
                    r_cnt   <= CNT_ZERO;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the registered state; everything is forced low while reset is held.
    always_comb begin
        o_req_ready  = 1'b0;
        o_unit_ctrl  = OP_IDLE;
        o_hilo_we    = 1'b0;
        o_done       = 1'b0;
        o_div0_exc   = 1'b0;
        o_busy       = 1'b0;
        o_stall      = 1'b0;
        o_illegal_op = r_illegal && !i_reset;
        if (!i_reset) begin
            case (r_state)
                ST_IDLE: begin
                    o_req_ready = 1'b1;
                end
                ST_RUN: begin
                    o_unit_ctrl = r_op;
                    o_busy      = 1'b1;
                    o_stall     = i_hilo_rd_req;
                end
                ST_CAPTURE: begin
                    o_unit_ctrl = r_op;
                    o_hilo_we   = 1'b1;
                    o_busy      = 1'b1;
                    o_stall     = i_hilo_rd_req;
                end
                ST_DONE: begin
                    o_done = 1'b1;
                    o_busy = 1'b1;
                end
                ST_EXC: begin
                    o_div0_exc = 1'b1;
                    o_busy     = 1'b1;
                end
                default: begin
                    o_busy = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: table of single-op vectors plus hand-written multi-cycle sequences.
// Commit events (hilo_we / div0_exc / illegal_op) are predicted into a queue and matched by a monitor.
// Per-cycle output words are compared against timing derived from the cycle-0 acceptance point.
module tb_muldiv_ctrl;

    localparam int N   = 33;
    localparam int ALL = 99;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_op;
    logic       req_ready;
    logic [1:0] unit_ctrl;
    logic       unit_div0;
    logic       hilo_we;
    logic       done;
    logic       div0_exc;
    logic       illegal_op;
    logic       busy;
    logic       hilo_rd_req;
    logic       stall;

    muldiv_ctrl #(.MULT_CYCLES(N), .DIV_CYCLES(N), .CNT_W(6)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req_valid  (req_valid),
        .i_req_op     (req_op),
        .o_req_ready  (req_ready),
        .o_unit_ctrl  (unit_ctrl),
        .i_unit_div0  (unit_div0),
        .o_hilo_we    (hilo_we),
        .o_done       (done),
        .o_div0_exc   (div0_exc),
        .o_illegal_op (illegal_op),
        .o_busy       (busy),
        .i_hilo_rd_req(hilo_rd_req),
        .o_stall      (stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // kind: 0 = done path (hilo_we), 1 = div0 abort, 2 = illegal drop
    typedef struct {
        logic [1:0] op;
        int         div0_at;
        int         kind;
        int         exp_end;
        int         exp_ready;
    } vec_t;

    typedef struct {
        int kind;
        int cycle;
    } sb_t;

    vec_t vecs[8];
    sb_t  sbq[$];

    localparam logic [8:0] IDLE_V = 9'b1_00_000000;

    // {ready, unit_ctrl, hilo_we, done, div0_exc, illegal_op, busy, stall}
    function automatic logic [8:0] outs();
        return {req_ready, unit_ctrl, hilo_we, done, div0_exc, illegal_op, busy, stall};
    endfunction

    function automatic logic [8:0] expv(vec_t v, int c);
        logic       rdy, we, dn, ex, il, bz;
        logic [1:0] uc;
        rdy = (c <= 0) || (c >= v.exp_ready);
        uc = 2'd0; we = 1'b0; dn = 1'b0; ex = 1'b0; il = 1'b0; bz = 1'b0;
        case (v.kind)
            0: begin
                uc = (c >= 1 && c <= v.exp_end) ? v.op : 2'd0;
                we = (c == v.exp_end);
                dn = (c == v.exp_end + 1);
                bz = (c >= 1 && c <= v.exp_end + 1);
            end
            1: begin
                uc = (c >= 1 && c < v.exp_end) ? v.op : 2'd0;
                ex = (c == v.exp_end);
                bz = (c >= 1 && c <= v.exp_end);
            end
            default: begin
                il = (c == v.exp_end);
            end
        endcase
        return {rdy, uc, we, dn, ex, il, bz, 1'b0};
    endfunction

    task automatic check_outs(string nm, int c, logic [8:0] exp);
        logic [8:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b (rdy,uc,we,done,exc,ill,busy,stall)",
                     nm, c, act, exp);
        end
    endtask

    // Scoreboard monitor: every commit-type pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (!reset && (hilo_we || div0_exc || illegal_op)) begin
            int  k;
            sb_t e;
            k = hilo_we ? 0 : (div0_exc ? 1 : 2);
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected cycle %0d: got event kind %0d expected none", cyc, k);
            end else begin
                e = sbq.pop_front();
                if (e.kind != k || e.cycle != cyc) begin
                    errors++;
                    $display("FAIL sb_event: got kind %0d at cycle %0d expected kind %0d at cycle %0d",
                             k, cyc, e.kind, e.cycle);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(vec_t v, int idx);
        int   t0;
        sb_t  e;
        t0 = cyc;
        e.kind  = v.kind;
        e.cycle = t0 + v.exp_end;
        sbq.push_back(e);
        for (int c = 0; c <= v.exp_ready + 1; c++) begin
            req_valid   = (c == 0);
            req_op      = v.op;
            unit_div0   = (v.div0_at == ALL && c >= 1) || (v.div0_at == c);
            hilo_rd_req = 1'b0;
            @(negedge clk);
            check_outs($sformatf("vec%0d", idx), c, expv(v, c));
            next_cycle();
        end
        req_valid = 1'b0;
        unit_div0 = 1'b0;
    endtask

    initial begin
        vec_t mrow, drow;
        sb_t  e;
        int   t0;
        logic [8:0] ex;

        reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; unit_div0 = 1'b0; hilo_rd_req = 1'b0;

        //          op    div0_at kind end ready
        vecs[0] = '{2'd2, 0,      0,   34, 36};  // mult, clean
        vecs[1] = '{2'd1, 0,      0,   34, 36};  // div, clean
        vecs[2] = '{2'd1, 5,      1,    6,  7};  // div0 in RUN cycle 5
        vecs[3] = '{2'd1, 1,      1,    2,  3};  // div0 on first RUN cycle
        vecs[4] = '{2'd1, 33,     1,   34, 35};  // div0 on last RUN cycle beats completion
        vecs[5] = '{2'd2, ALL,    0,   34, 36};  // mult ignores div0
        vecs[6] = '{2'd3, 0,      2,    1,  1};  // illegal op 3
        vecs[7] = '{2'd0, 0,      2,    1,  1};  // illegal op 0
        mrow = vecs[0];
        drow = vecs[1];

        // Reset state, with a request presented during reset that must not be taken.
        next_cycle();
        req_valid = 1'b1; req_op = 2'd2;
        @(negedge clk);
        check_outs("reset_outs", 0, 9'b0);
        next_cycle();
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check_outs("post_reset_idle", 0, IDLE_V);
        next_cycle();
        @(negedge clk);
        check_outs("reset_req_dropped", 1, IDLE_V);
        next_cycle();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Request held while busy: second mult accepted exactly when ready returns.
        t0 = cyc;
        e.kind = 0; e.cycle = t0 + 34; sbq.push_back(e);
        e.kind = 0; e.cycle = t0 + 70; sbq.push_back(e);
        for (int c = 0; c <= 73; c++) begin
            req_valid = (c <= 36);
            req_op    = 2'd2;
            @(negedge clk);
            ex = (c <= 36) ? expv(mrow, c) : expv(mrow, c - 36);
            check_outs("held_req", c, ex);
            next_cycle();
        end
        req_valid = 1'b0;

        // mfhi/mflo stall window during a mult.
        t0 = cyc;
        e.kind = 0; e.cycle = t0 + 34; sbq.push_back(e);
        for (int c = 0; c <= 41; c++) begin
            req_valid   = (c == 0);
            req_op      = 2'd2;
            hilo_rd_req = (c >= 10 && c <= 40);
            @(negedge clk);
            ex = expv(mrow, c);
            ex[0] = (c >= 10 && c <= 34);
            check_outs("stall", c, ex);
            next_cycle();
        end
        hilo_rd_req = 1'b0;

        // Reset in the middle of a div: no commit event may ever appear for it.
        for (int c = 0; c <= 45; c++) begin
            req_valid = (c == 0);
            req_op    = 2'd1;
            reset     = (c == 20);
            @(negedge clk);
            if (c < 20)       check_outs("mid_reset", c, expv(drow, c));
            else if (c == 20) check_outs("mid_reset", c, 9'b0);
            else              check_outs("mid_reset", c, IDLE_V);
            next_cycle();
        end
        reset = 1'b0;
        req_valid = 1'b0;

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending events expected 0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
